// File: rtl/branch_redirect_unit.sv
// Fetch-side redirect unit: steers the PC from predictor guesses, tracks in-flight branches and squashes the wrong path.
// Optional MISPRED_CNT_EN adds saturating resolved-branch and mispredict counters.
module branch_redirect_unit #(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     FLUSH_CYC = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            if_is_branch,
  input  logic [PC_W-1:0] if_target,
  input  logic            pred_taken,
  input  logic            ex_resolve,
  input  logic            ex_taken,
  output logic [PC_W-1:0] pc_out,
  output logic            if_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            q_full,
  output logic            q_empty,
`ifdef MISPRED_CNT_EN
  output logic [15:0]     br_cnt,
  output logic [15:0]     mis_cnt,
`endif
  output logic            resolve_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int FCW  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            hold_q, hold_d;
  logic            err_q, err_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            pred_mem [DEPTH];
  logic [PC_W-1:0] rec_mem  [DEPTH];

  logic            run, resolve_ok, mispred, pop, push;
  logic [PC_W-1:0] pc_inc, rec_new;

  assign run        = (state_q == RUN);
  assign q_empty    = (cnt_q == '0);
  assign q_full     = (cnt_q == CNTW'(DEPTH));
  assign pc_inc     = pc_q + PC_W'(1);
  assign rec_new    = pred_taken ? pc_inc : if_target;
  assign resolve_ok = run && ex_resolve && !q_empty;
  assign mispred    = resolve_ok && (pred_mem[rd_q] != ex_taken);
  assign pop        = resolve_ok && !mispred;
  // A correct pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push       = run && !mispred && !stall && if_is_branch && (!q_full || pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = 1'b0;
    fcnt_d  = fcnt_q;
    err_d   = err_q | (run && ex_resolve && q_empty);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mispred) begin
          pc_d    = rec_mem[rd_q];
          state_d = FLUSH;
          fcnt_d  = FCW'(FLUSH_CYC - 1);
        end else if (stall) begin
          pc_d = pc_q;
        end else if (if_is_branch) begin
          if (push) pc_d = pred_taken ? if_target : pc_inc;
          else      hold_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = RUN;
        else              fcnt_d  = fcnt_q - FCW'(1);
      end
      default: state_d = RUN;
    endcase
    // Everything younger than a mispredicted branch is wrong-path
    if (mispred) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pred_mem[wr_q] <= pred_taken;
      rec_mem[wr_q]  <= rec_new;
    end
  end

`ifdef MISPRED_CNT_EN
  logic [15:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (resolve_ok && (br_cnt_q != 16'hFFFF)) br_cnt_q  <= br_cnt_q + 16'd1;
      if (mispred && (mis_cnt_q != 16'hFFFF))   mis_cnt_q <= mis_cnt_q + 16'd1;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`endif

  assign pc_out      = pc_q;
  assign if_valid    = !rst && run && !hold_q;
  assign flush_if_id = (state_q == FLUSH);
  assign flush_id_ex = (state_q == FLUSH);
  assign resolve_err = err_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: per-cycle expected outputs are queued by the stimulus
// and compared by an independent monitor on the falling edge.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst, stall, if_is_branch, pred_taken, ex_resolve, ex_taken;
  logic [15:0] if_target;
  logic [15:0] pc_out;
  logic        if_valid, flush_if_id, flush_id_ex, q_full, q_empty, resolve_err;
`ifdef MISPRED_CNT_EN
  logic [15:0] br_cnt, mis_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic        v, fl, fu, em, er;
  } exp_t;

  exp_t expQ[$];

  branch_redirect_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .if_is_branch(if_is_branch),
    .if_target(if_target), .pred_taken(pred_taken), .ex_resolve(ex_resolve),
    .ex_taken(ex_taken), .pc_out(pc_out), .if_valid(if_valid),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .q_full(q_full),
    .q_empty(q_empty),
`ifdef MISPRED_CNT_EN
    .br_cnt(br_cnt), .mis_cnt(mis_cnt),
`endif
    .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.nm, ".pc"},    32'(pc_out),      32'(e.pc));
        checkOutput({e.nm, ".valid"}, 32'(if_valid),    32'(e.v));
        checkOutput({e.nm, ".fifd"},  32'(flush_if_id), 32'(e.fl));
        checkOutput({e.nm, ".fidx"},  32'(flush_id_ex), 32'(e.fl));
        checkOutput({e.nm, ".full"},  32'(q_full),      32'(e.fu));
        checkOutput({e.nm, ".empty"}, 32'(q_empty),     32'(e.em));
        checkOutput({e.nm, ".err"},   32'(resolve_err), 32'(e.er));
      end
    end
  end

  task automatic drive(input logic br, input logic [15:0] tgt, input logic pr,
                       input logic res, input logic tk, input logic st);
    if_is_branch = br;
    if_target    = tgt;
    pred_taken   = pr;
    ex_resolve   = res;
    ex_taken     = tk;
    stall        = st;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the outputs expected during the current cycle, then advance one clock
  task automatic applyStimulus(input string nm, input logic [15:0] pc, input logic v,
                               input logic fl, input logic fu, input logic em, input logic er);
    exp_t e;
    e.nm = nm; e.pc = pc; e.v = v; e.fl = fl; e.fu = fu; e.em = em; e.er = er;
    expQ.push_back(e);
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    applyStimulus("reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 5; i++) applyStimulus("seq", 16'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Predicted taken, resolved taken
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus("tk_pre", 16'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("tk_br", 16'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus("tk_tgt", 16'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("tk_res", 16'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    applyStimulus("tk_post", 16'd22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Predicted taken, actually not taken; resolves and stalls ignored during flush
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus("mp_pre", 16'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("mp_br", 16'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("mp_res", 16'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("mp_fl1", 16'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("mp_fl2", 16'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus("mp_rs4", 16'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("mp_rs5", 16'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // PC wrap through all-ones
    doReset();
    drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("wr_br", 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus("wr_max", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("wr_zero", 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    applyStimulus("wr_one", 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fill the FIFO, block on full, then push alongside a correct pop
    doReset();
    drive(1'b1, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("fu_b1", 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'd50, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("fu_b2", 16'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd40, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("fu_b3", 16'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd60, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("fu_b4", 16'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd70, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("fu_blk", 16'd60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'd70, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("fu_hold", 16'd60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("fu_swap", 16'd70, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    applyStimulus("fu_fl1", 16'd50, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("fu_fl2", 16'd50, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("fu_rec", 16'd50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Resolve with empty FIFO is sticky; stall holds the PC
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("er_res", 16'd51, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("er_stl", 16'd52, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    applyStimulus("er_hld", 16'd52, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus("er_rst", 16'd53, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    applyStimulus("er_clr", 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a flush
    drive(1'b1, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rf_br", 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("rf_res", 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    applyStimulus("rf_fl", 16'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus("rf_clr", 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef MISPRED_CNT_EN
    doReset();
    drive(1'b1, 16'd20, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'd30, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 16'd40, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);  tick();
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);  tick();
    idle(); tick(); tick();
    drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);  tick();
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);  tick();
    idle();
    checkOutput("cnt.br", 32'(br_cnt), 32'd3);
    checkOutput("cnt.mis", 32'(mis_cnt), 32'd1);
    doReset();
    checkOutput("cnt.br_rst", 32'(br_cnt), 32'd0);
    checkOutput("cnt.mis_rst", 32'(mis_cnt), 32'd0);
`endif

    @(negedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
